// File: rtl/frame_timer.sv
// Frame-count timer for song sequencing: counts new_frame rising edges
// once started, with pause, abort, restart and optional wrap-around loop.
module frame_timer #(
   parameter int WIDTH     = 16,
   parameter int LIMIT     = 5680,
   parameter bit LOOP_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_sign,
   input  logic             pause_sign,
   input  logic             abort_sign,
   input  logic             new_frame,
   output logic [WIDTH-1:0] un_time,
   output logic             stop_sign,
   output logic             running,
   output logic             paused,
   output logic             wrap_pulse
);

   if ((LIMIT < 1) || (longint'(LIMIT) >= (longint'(1) << WIDTH))) begin : g_lim_chk
      $error("frame_timer: LIMIT must be in 1 .. 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] LIM  = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   typedef enum logic [1:0] {HALTED, RUN, PAUSE, DONE} state_t;

   state_t state;
   logic   nf_q;
   logic   tick;

   // nf_q resets high so a frame strobe already high at release is not a tick
   assign tick = new_frame & ~nf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HALTED;
         un_time    <= '0;
         nf_q       <= 1'b1;
         stop_sign  <= 1'b0;
         running    <= 1'b0;
         paused     <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         nf_q       <= new_frame;
         wrap_pulse <= 1'b0;
         if (abort_sign) begin
            state     <= HALTED;
            un_time   <= '0;
            stop_sign <= 1'b0;
            running   <= 1'b0;
            paused    <= 1'b0;
         end else begin
            unique case (state)
               HALTED: begin
                  if (start_sign) begin
                     state   <= RUN;
                     un_time <= '0;
                     running <= 1'b1;
                  end
               end
               RUN: begin
                  if (pause_sign) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                     paused  <= 1'b1;
                  end else if (tick) begin
                     if (un_time == LAST) begin
                        wrap_pulse <= 1'b1;
                        if (LOOP_MODE) begin
                           un_time <= '0;
                        end else begin
                           un_time   <= LIM;
                           state     <= DONE;
                           stop_sign <= 1'b1;
                           running   <= 1'b0;
                        end
                     end else begin
                        un_time <= un_time + 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (!pause_sign) begin
                     state   <= RUN;
                     running <= 1'b1;
                     paused  <= 1'b0;
                  end
               end
               DONE: begin
                  if (start_sign) begin
                     state     <= RUN;
                     un_time   <= '0;
                     stop_sign <= 1'b0;
                     running   <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule
